// File: rtl/dds_wave_meas_pkg.sv
// Shared definitions for the DDS waveform measurement block.
// Latency: n/a (types and defaults only).
// Backpressure: n/a.
package dds_wave_meas_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int CNT_W_DEF   = 20;
    localparam int MID_DEF     = 128;
    localparam int HYST_DEF    = 8;
    localparam int TIMEOUT_DEF = 2**20 - 1;

    // Encoding is shared with the DDS generator blocks, keep the values fixed.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } meas_state_t;

endpackage

// File: rtl/dds_wave_meas_hyst_cmp.sv
// Input register plus hysteresis comparator around the mid-code.
// Latency: 1 cycle din -> d_q/v_q; rise is combinational from d_q and the held level.
// Backpressure: none; samples are accepted every cycle din_vld is high.
//
// Ports:
//   clk, rst      clock, async active-high reset
//   din, din_vld  raw waveform sample and its valid
//   d_q, v_q      registered sample and valid, used by all downstream logic
//   rise          registered sample is the first one at/above the high threshold
module dds_wave_meas_hyst_cmp #(
    parameter int DATA_W = 8,
    parameter int MID    = 128,
    parameter int HYST   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic [DATA_W-1:0] d_q,
    output logic              v_q,
    output logic              rise
);

    localparam logic [DATA_W:0] HI_TH = (DATA_W+1)'(MID + HYST);
    localparam logic [DATA_W:0] LO_TH = (DATA_W+1)'(MID - HYST);

    logic lvl;
    logic at_hi;
    logic at_lo;

    assign at_hi = ({1'b0, d_q} >= HI_TH);
    assign at_lo = ({1'b0, d_q} <= LO_TH);

    // Uses the level before this sample updates it, so only the first
    // high sample after a low excursion counts as a crossing.
    assign rise = v_q & ~lvl & at_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= '0;
            v_q <= 1'b0;
            lvl <= 1'b0;
        end else begin
            d_q <= din;
            v_q <= din_vld;
            // Inside the band the level holds; that is what rejects noise.
            if (v_q) begin
                if (at_hi) begin
                    lvl <= 1'b1;
                end else if (at_lo) begin
                    lvl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dds_wave_meas.sv
// Measures period, extrema and peak-to-peak of the DDS waveform stream.
// Latency: sample driven before edge N+1 (captured there) -> result_vld after edge N+2.
// Backpressure: none; invalid cycles simply freeze counting and extrema.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   meas_en             low forces IDLE, results hold
//   din, din_vld        waveform sample and valid
//   period              valid samples between consecutive rising crossings
//   vmax, vmin, vpp     extrema of the last complete window and their difference
//   result_vld          1-cycle pulse when the result registers update
//   no_signal           set on timeout, cleared by the next result
//   busy                high in ARM or MEASURE
module dds_wave_meas
    import dds_wave_meas_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MID     = MID_DEF,
    parameter int HYST    = HYST_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              meas_en,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic [CNT_W-1:0]  period,
    output logic [DATA_W-1:0] vmax,
    output logic [DATA_W-1:0] vmin,
    output logic [DATA_W-1:0] vpp,
    output logic              result_vld,
    output logic              no_signal,
    output logic              busy
);

    // A valid non-crossing sample arriving while cnt sits here would make
    // TIMEOUT samples without a crossing, so that sample trips the timeout.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [DATA_W-1:0] d_q;
    logic              v_q;
    logic              rise;

    meas_state_t       state;
    meas_state_t       state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] wmax;
    logic [DATA_W-1:0] wmin;

    logic cnt_clr;
    logic cnt_inc;
    logic win_start;
    logic win_grow;
    logic emit;
    logic tmo;

    dds_wave_meas_hyst_cmp #(
        .DATA_W (DATA_W),
        .MID    (MID),
        .HYST   (HYST)
    ) u_cmp (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .din_vld (din_vld),
        .d_q     (d_q),
        .v_q     (v_q),
        .rise    (rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        win_start = 1'b0;
        win_grow  = 1'b0;
        emit      = 1'b0;
        tmo       = 1'b0;
        if (!meas_en) begin
            // Disable wins over everything, including a crossing this cycle.
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_ARM;
                    cnt_clr   = 1'b1;
                end
                ST_ARM: begin
                    if (rise) begin
                        state_nxt = ST_MEASURE;
                        win_start = 1'b1;
                    end else if (v_q) begin
                        if (cnt == CNT_LAST) begin
                            tmo     = 1'b1;
                            cnt_clr = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        emit      = 1'b1;
                        win_start = 1'b1;
                    end else if (v_q) begin
                        if (cnt == CNT_LAST) begin
                            tmo       = 1'b1;
                            cnt_clr   = 1'b1;
                            state_nxt = ST_ARM;
                        end else begin
                            cnt_inc  = 1'b1;
                            win_grow = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            wmax       <= '0;
            wmin       <= '0;
            period     <= '0;
            vmax       <= '0;
            vmin       <= '0;
            vpp        <= '0;
            result_vld <= 1'b0;
            no_signal  <= 1'b0;
        end else begin
            result_vld <= emit;

            if (cnt_clr) begin
                cnt <= '0;
            end else if (win_start) begin
                cnt <= CNT_W'(1);
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end

            // The crossing sample opens the new window; the old window's
            // extrema are latched from wmax/wmin before they are reseeded.
            if (win_start) begin
                wmax <= d_q;
                wmin <= d_q;
            end else if (win_grow) begin
                if (d_q > wmax) begin
                    wmax <= d_q;
                end
                if (d_q < wmin) begin
                    wmin <= d_q;
                end
            end

            if (emit) begin
                period    <= cnt;
                vmax      <= wmax;
                vmin      <= wmin;
                vpp       <= wmax - wmin;
                no_signal <= 1'b0;
            end else if (tmo) begin
                no_signal <= 1'b1;
            end
        end
    end

    assign busy = (state == ST_ARM) || (state == ST_MEASURE);

endmodule

// File: tb/tb_dds_wave_meas.sv
// Self-checking bench for dds_wave_meas with a queue-based reference model.
// Latency: model result lines up with the DUT two edges after a sample is driven.
// Backpressure: n/a.
module tb_dds_wave_meas;

    localparam int DW  = 8;
    localparam int CW  = 20;
    localparam int TMO = 1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          meas_en;
    logic [DW-1:0] din;
    logic          din_vld;
    logic [CW-1:0] period;
    logic [DW-1:0] vmax;
    logic [DW-1:0] vmin;
    logic [DW-1:0] vpp;
    logic          result_vld;
    logic          no_signal;
    logic          busy;

    always #5 clk = ~clk;

    dds_wave_meas #(
        .DATA_W  (DW),
        .CNT_W   (CW),
        .MID     (128),
        .HYST    (8),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .meas_en    (meas_en),
        .din        (din),
        .din_vld    (din_vld),
        .period     (period),
        .vmax       (vmax),
        .vmin       (vmin),
        .vpp        (vpp),
        .result_vld (result_vld),
        .no_signal  (no_signal),
        .busy       (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: comparator level, whether the block is enabled and
    // armed, the samples of the open window, and the expected outputs.
    bit   m_lvl;
    bit   m_armed;
    bit   m_meas;
    int   m_arm_cnt;
    int   win[$];
    int   e_period, e_vmax, e_vmin, e_vpp;
    bit   e_nosig;
    bit   e_emit;
    // Values driven one and two steps ago (what the DUT sees at the next edge).
    logic [7:0] h1_din, h2_din;
    bit         h1_vld, h2_vld, h1_en;
    int         k;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        assert (act === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    endtask

    function automatic void model_reset();
        m_lvl = 0; m_armed = 0; m_meas = 0; m_arm_cnt = 0;
        win.delete();
        e_period = 0; e_vmax = 0; e_vmin = 0; e_vpp = 0;
        e_nosig = 0; e_emit = 0;
        h2_din = 0; h2_vld = 0; h1_vld = 0; h1_en = 0;
    endfunction

    function automatic void model_edge();
        int  s, mx, mn, n;
        bit  v, en, rise;
        s  = int'(h2_din);
        v  = h2_vld;
        en = h1_en;
        e_emit = 0;
        rise = v && !m_lvl && (s >= 136);
        if (v) begin
            if (s >= 136) m_lvl = 1;
            else if (s <= 120) m_lvl = 0;
        end
        if (!en) begin
            m_armed = 0;
            m_meas  = 0;
        end else if (!m_armed) begin
            m_armed = 1; m_meas = 0; m_arm_cnt = 0;
            win.delete();
        end else if (rise) begin
            if (m_meas) begin
                mx = 0; mn = 255;
                foreach (win[i]) begin
                    if (win[i] > mx) mx = win[i];
                    if (win[i] < mn) mn = win[i];
                end
                e_emit = 1; e_period = win.size();
                e_vmax = mx; e_vmin = mn; e_vpp = mx - mn;
                e_nosig = 0;
            end
            win.delete();
            win.push_back(s);
            m_meas = 1;
        end else if (v) begin
            n = m_meas ? win.size() : m_arm_cnt;
            if (n == TMO - 1) begin
                e_nosig = 1; m_meas = 0; m_arm_cnt = 0;
                win.delete();
            end else if (m_meas) begin
                win.push_back(s);
            end else begin
                m_arm_cnt++;
            end
        end
    endfunction

    task automatic step(input logic [7:0] d, input logic v, input logic en);
        @(posedge clk);
        model_edge();
        #1;
        if (e_emit || result_vld !== 1'b0) begin
            chk("result_vld", 32'(result_vld), 32'(e_emit));
            if (e_emit) begin
                chk("period", 32'(period), e_period);
                chk("vmax", 32'(vmax), e_vmax);
                chk("vmin", 32'(vmin), e_vmin);
                chk("vpp", 32'(vpp), e_vpp);
            end
        end
        chk("no_signal", 32'(no_signal), 32'(e_nosig));
        chk("busy", 32'(busy), 32'(m_armed));
        h2_din = h1_din; h2_vld = h1_vld;
        h1_din = d; h1_vld = v; h1_en = en;
        din = d; din_vld = v; meas_en = en;
    endtask

    function automatic logic [7:0] tri256(input int i);
        int t;
        t = i % 256;
        return (t <= 127) ? 8'(2 * t) : 8'(510 - 2 * t);
    endfunction

    // mode 0: always valid, 1: valid on alternate cycles, 2: random 75% valid.
    // Invalid cycles carry random junk that must be ignored.
    task automatic tri_run(input int n, input int mode, input logic en);
        logic v;
        for (int i = 0; i < n; i++) begin
            case (mode)
                1:       v = (i % 2 == 0);
                2:       v = ($urandom_range(0, 3) != 0);
                default: v = 1'b1;
            endcase
            if (v) begin
                step(tri256(k), 1'b1, en);
                k++;
            end else begin
                step(8'($urandom), 1'b0, en);
            end
        end
    endtask

    task automatic spec_check(input string tag);
        chk({tag, "_period"}, 32'(period), 256);
        chk({tag, "_vmax"}, 32'(vmax), 254);
        chk({tag, "_vmin"}, 32'(vmin), 0);
        chk({tag, "_vpp"}, 32'(vpp), 254);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_period"}, 32'(period), 0);
        chk({tag, "_vmax"}, 32'(vmax), 0);
        chk({tag, "_vmin"}, 32'(vmin), 0);
        chk({tag, "_vpp"}, 32'(vpp), 0);
        chk({tag, "_result_vld"}, 32'(result_vld), 0);
        chk({tag, "_no_signal"}, 32'(no_signal), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic reset_mid_window();
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("async_rst");
        meas_en = 1'b0;
        din_vld = 1'b0;
        model_reset();
        h1_din = din;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int base, nz, val, lo_n, mid_n, hi_n;
        rst = 1'b1; meas_en = 1'b0; din = '0; din_vld = 1'b0;
        model_reset();
        h1_din = 0;
        #1 check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        // Full-rate triangle from a random starting phase.
        k = $urandom_range(0, 255);
        tri_run(1280, 0, 1'b1);
        spec_check("tri");

        // Alternating and random valid patterns with junk on idle cycles.
        tri_run(1536, 1, 1'b1);
        spec_check("tri_toggle");
        tri_run(1024, 2, 1'b1);
        spec_check("tri_randvld");

        // Stuck inside the hysteresis band until timeout.
        for (int i = 0; i < 1100; i++) step(8'd130, 1'b1, 1'b1);
        chk("stuck_no_signal", 32'(no_signal), 1);
        chk("stuck_busy", 32'(busy), 1);
        chk("stuck_period_hold", 32'(period), 256);
        chk("stuck_vpp_hold", 32'(vpp), 254);

        // Slow ramp with alternating small noise around the threshold.
        for (int i = 0; i < 1536; i++) begin
            base = i % 512;
            base = (base < 256) ? base : 511 - base;
            nz   = $urandom_range(0, 3);
            val  = (i % 2 == 1) ? base + nz : base - nz;
            if (val < 0) val = 0;
            if (val > 255) val = 255;
            step(8'(val), 1'b1, 1'b1);
        end
        chk("noise_no_signal_cleared", 32'(no_signal), 0);

        // Enable dropped mid-window for 50 cycles.
        tri_run(300, 0, 1'b1);
        tri_run(50, 0, 1'b0);
        tri_run(800, 0, 1'b1);
        spec_check("en_drop");

        // Asynchronous reset mid-window, then re-enable.
        tri_run(100, 0, 1'b1);
        reset_mid_window();
        tri_run(800, 0, 1'b1);
        spec_check("after_rst");

        // Exact threshold codes: 120 re-arms, 121 does not; 136 rises, 135 does not.
        for (int c = 0; c < 8; c++) begin
            lo_n  = $urandom_range(1, 12);
            mid_n = $urandom_range(1, 6);
            hi_n  = $urandom_range(1, 12);
            for (int i = 0; i < lo_n; i++)  step(8'd120, 1'b1, 1'b1);
            for (int i = 0; i < mid_n; i++) step(8'd135, 1'b1, 1'b1);
            step(8'd200, 1'b0, 1'b1);
            for (int i = 0; i < hi_n; i++)  step(8'd136, 1'b1, 1'b1);
            for (int i = 0; i < mid_n; i++) step(8'd121, 1'b1, 1'b1);
        end
        for (int i = 0; i < 4; i++) step(8'd120, 1'b1, 1'b1);
        chk("thresh_vmax", 32'(vmax), 136);
        chk("thresh_vmin", 32'(vmin), 120);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
